// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side packer.
package fifo_pkg;

    localparam int BYTE_W         = 8;
    localparam int MAX_WORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Self-pacing FIFO drain: pops bytes and packs them little-endian into words on valid/ready.
// Define FIFO_RD_FLUSH_EN to flush a partial word after TIMEOUT idle cycles.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                         rd_clk,
    input  logic                         reset_n,
    input  logic                         empty,
    input  logic [BYTE_W-1:0]            data_out,
    output logic                         rd,
    output logic [BYTE_W*WORD_BYTES-1:0] word_out,
    output logic [3:0]                   word_bytes,
    output logic                         word_valid,
    input  logic                         word_ready
);

    if (WORD_BYTES < 2 || WORD_BYTES > MAX_WORD_BYTES || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("fifo_rd_packer: WORD_BYTES must be 2..8 and TIMEOUT 1..255");
    end

    rd_state_t                     r_state;
    rd_state_t                     w_state_nxt;
    logic [BYTE_W*WORD_BYTES-1:0]  r_lanes;
    logic [3:0]                    r_byte_cnt;
    logic [3:0]                    w_cnt_inc;
    logic                          w_timeout;

    assign w_cnt_inc = r_byte_cnt + 4'd1;

`ifdef FIFO_RD_FLUSH_EN
    logic [7:0] r_idle_cnt;

    assign w_timeout = (r_byte_cnt != 4'd0) && (r_idle_cnt == 8'(TIMEOUT - 1));

    // Counts only while a partial word is waiting on an empty FIFO.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= 8'd0;
        end else if (r_state != IDLE) begin
            r_idle_cnt <= 8'd0;
        end else if (empty && r_byte_cnt != 4'd0) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        rd          = 1'b0;
        word_valid  = 1'b0;
        word_bytes  = 4'd0;
        case (r_state)
            IDLE: begin
                rd = !empty && reset_n;
                if (!empty) begin
                    w_state_nxt = FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = OUT;
                end
            end
            FETCH: begin
                w_state_nxt = (w_cnt_inc == 4'(WORD_BYTES)) ? OUT : IDLE;
            end
            OUT: begin
                word_valid = 1'b1;
                word_bytes = r_byte_cnt;
                if (word_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The lane register is cleared on accept, so unused lanes of a flushed word read zero.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lanes    <= '0;
            r_byte_cnt <= 4'd0;
        end else begin
            case (r_state)
                FETCH: begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (r_byte_cnt == 4'(i)) begin
                            r_lanes[i*BYTE_W +: BYTE_W] <= data_out;
                        end
                    end
                    r_byte_cnt <= w_cnt_inc;
                end
                OUT: begin
                    if (word_ready) begin
                        r_lanes    <= '0;
                        r_byte_cnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign word_out = r_lanes;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: directed table, corner sequences and a randomized scoreboard.
// Flush expectations follow FIFO_RD_FLUSH_EN.
module tb_fifo_rd_packer;

    localparam int WB  = 4;
    localparam int WB2 = 2;
    localparam int TO  = 16;

    logic        rd_clk = 1'b0;
    logic        reset_n;
    logic        empty;
    logic [7:0]  data_out = 8'h00;
    logic        rd;
    logic [31:0] word_out;
    logic [3:0]  word_bytes;
    logic        word_valid;
    logic        word_ready;

    logic        empty2;
    logic [7:0]  data_out2 = 8'h00;
    logic        rd2;
    logic [15:0] word_out2;
    logic [3:0]  word_bytes2;
    logic        word_valid2;
    logic        word_ready2;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_packer #(.WORD_BYTES(WB), .TIMEOUT(TO)) u_dut (
        .rd_clk(rd_clk), .reset_n(reset_n), .empty(empty), .data_out(data_out), .rd(rd),
        .word_out(word_out), .word_bytes(word_bytes), .word_valid(word_valid), .word_ready(word_ready)
    );

    fifo_rd_packer #(.WORD_BYTES(WB2), .TIMEOUT(TO)) u_dut2 (
        .rd_clk(rd_clk), .reset_n(reset_n), .empty(empty2), .data_out(data_out2), .rd(rd2),
        .word_out(word_out2), .word_bytes(word_bytes2), .word_valid(word_valid2), .word_ready(word_ready2)
    );

    // Behavioural source FIFOs: the bench pushes, the DUT pops with rd, data appears next cycle.
    logic [7:0] mem [0:1023];
    logic [9:0] wr_ptr = '0;
    logic [9:0] rd_ptr = '0;
    logic       tb_block = 1'b0;
    assign empty = (rd_ptr == wr_ptr) || tb_block;

    always @(posedge rd_clk) begin
        if (rd) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 10'd1;
        end
    end

    logic [7:0] mem2 [0:15];
    logic [3:0] wr2 = '0;
    logic [3:0] rp2 = '0;
    assign empty2 = (rp2 == wr2);

    always @(posedge rd_clk) begin
        if (rd2) begin
            data_out2 <= mem2[rp2];
            rp2       <= rp2 + 4'd1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2] = b;
        wr2 = wr2 + 4'd1;
    endtask

    // Reference model: the byte stream chunked into groups of WB, first byte in the low lane.
    logic [31:0] exp_q [$];
    logic [31:0] acc = '0;
    int          nacc = 0;
    bit          sb_en = 1'b0;

    task automatic push_sb(input logic [7:0] b);
        push(b);
        acc = acc | (32'(b) << (8 * nacc));
        nacc++;
        if (nacc == WB) begin
            exp_q.push_back(acc);
            acc  = '0;
            nacc = 0;
        end
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        @(negedge rd_clk);
        while (!word_valid && cycles < limit) begin
            @(negedge rd_clk);
            cycles++;
        end
        check("wait_valid", word_valid, 1);
    endtask

    // Protocol monitor, sampled on the falling edge.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_word  = '0;

    always @(negedge rd_clk) begin
        if (reset_n) begin
            if (empty)      check("rd_while_empty", rd, 0);
            if (word_valid) check("rd_in_out", rd, 0);
            if (prev_valid && !prev_ready) begin
                check("valid_held", word_valid, 1);
                check("word_stable", word_out, prev_word);
            end
            if (sb_en && word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", word_valid, 0);
                end else begin
                    check("sb_word", word_out, exp_q.pop_front());
                    check("sb_bytes", word_bytes, 4);
                end
            end
        end
        prev_valid = word_valid & reset_n;
        prev_ready = word_ready;
        prev_word  = word_out;
    end

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          delay;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          rd_cnt;
        int          rd_at [4];
        int          valid_cnt;
        int          valid_at;
        logic [31:0] w1;
        logic [3:0]  b1;
        int          to_push;

        tbl[0] = '{8'h10, 8'h11, 8'h12, 8'h13, 5, 32'h13121110};
        tbl[1] = '{8'h14, 8'h15, 8'h16, 8'h17, 0, 32'h17161514};
        tbl[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 3, 32'hEFBEADDE};
        tbl[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 1, 32'hFF00FF00};

        // Reset with the FIFO preloaded.
        reset_n     = 1'b0;
        word_ready  = 1'b1;
        word_ready2 = 1'b1;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick();
        check("reset_rd", rd, 0);
        check("reset_word_out", word_out, 0);
        check("reset_word_bytes", word_bytes, 0);
        check("reset_word_valid", word_valid, 0);
        tick();
        reset_n = 1'b1;

        rd_cnt    = 0;
        valid_cnt = 0;
        valid_at  = -1;
        w1        = '0;
        b1        = '0;
        foreach (rd_at[i]) rd_at[i] = -100;
        for (int c = 0; c < 30; c++) begin
            @(negedge rd_clk);
            if (rd) begin
                if (rd_cnt < 4) rd_at[rd_cnt] = c;
                rd_cnt++;
            end
            if (word_valid) begin
                if (valid_cnt == 0) begin
                    valid_at = c;
                    w1 = word_out;
                    b1 = word_bytes;
                end
                valid_cnt++;
            end
        end
        check("first_rd_count", rd_cnt, 4);
        for (int i = 1; i < 4; i++) check("rd_spacing", rd_at[i] - rd_at[i-1], 2);
        check("first_word_latency", valid_at - rd_at[0], 2 * WB);
        check("first_valid_pulse", valid_cnt, 1);
        check("first_word", w1, 32'h04030201);
        check("first_bytes", b1, 4);
        tick();

        // Table: all words queued up front so the FIFO is non-empty while OUT stalls.
        foreach (tbl[v]) begin
            push(tbl[v].b0); push(tbl[v].b1); push(tbl[v].b2); push(tbl[v].b3);
        end
        for (int v = 0; v < 4; v++) begin
            word_ready = (tbl[v].delay == 0);
            wait_valid(40, cyc);
            check("tbl_word", word_out, tbl[v].exp);
            check("tbl_bytes", word_bytes, 4);
            if (tbl[v].delay > 0) begin
                repeat (tbl[v].delay) begin
                    @(negedge rd_clk);
                    check("tbl_hold_word", word_out, tbl[v].exp);
                end
                tick();
                word_ready = 1'b1;
                @(negedge rd_clk);
                check("tbl_valid_at_accept", word_valid, 1);
            end
            tick();
            @(negedge rd_clk);
            check("tbl_valid_drop", word_valid, 0);
            tick();
        end

        // Reset after two bytes of a word, with a pop pending.
        word_ready = 1'b1;
        push(8'h55); push(8'h66);
        repeat (6) tick();
        push(8'h21);
        #1;
        check("pre_reset_rd", rd, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_rd", rd, 0);
        check("async_reset_valid", word_valid, 0);
        check("async_reset_word", word_out, 0);
        check("async_reset_bytes", word_bytes, 0);
        tick();
        tick();
        reset_n = 1'b1;
        push(8'h22); push(8'h23); push(8'h24);
        wait_valid(40, cyc);
        check("post_reset_word", word_out, 32'h24232221);
        check("post_reset_bytes", word_bytes, 4);
        tick();
        tick();

        // Partial word on a drained FIFO.
        push(8'hAA); push(8'hBB); push(8'hCC);
`ifdef FIFO_RD_FLUSH_EN
        rd_cnt    = 0;
        valid_at  = -1;
        rd_at[2]  = -100;
        for (int c = 0; c < 60; c++) begin
            @(negedge rd_clk);
            if (rd) begin
                if (rd_cnt < 4) rd_at[rd_cnt] = c;
                rd_cnt++;
            end
            if (word_valid && valid_at < 0) begin
                valid_at = c;
                w1 = word_out;
                b1 = word_bytes;
            end
        end
        check("flush_latency", valid_at - rd_at[2], 2 + TO);
        check("flush_word", w1, 32'h00CCBBAA);
        check("flush_bytes", b1, 3);
        tick();
`else
        valid_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge rd_clk);
            if (word_valid) valid_cnt++;
        end
        check("no_flush_valid", valid_cnt, 0);
        tick();
        push(8'hDD);
        wait_valid(40, cyc);
        check("completed_word", word_out, 32'hDDCCBBAA);
        check("completed_bytes", word_bytes, 4);
        tick();
        tick();
`endif

        // Empty toggling every cycle; scoreboard checks order and exactly-once capture.
        sb_en = 1'b1;
        word_ready = 1'b1;
        for (int i = 0; i < 5 * WB; i++) push_sb(8'($urandom_range(0, 255)));
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            tick();
            tb_block = ~tb_block;
        end
        tb_block = 1'b0;
        check("toggle_drain", exp_q.size(), 0);

        // Randomized pushes, FIFO stalls and back-pressure.
        to_push = 60 * WB;
        for (int c = 0; c < 3000 && (to_push > 0 || exp_q.size() > 0); c++) begin
            tick();
            if (to_push > 0 && $urandom_range(0, 3) != 0) begin
                push_sb(8'($urandom_range(0, 255)));
                to_push--;
            end
            tb_block   = ($urandom_range(0, 3) == 0);
            word_ready = 1'($urandom_range(0, 1));
        end
        tb_block   = 1'b0;
        word_ready = 1'b1;
        check("random_drain", exp_q.size(), 0);
        tick();
        sb_en = 1'b0;

        // Two-byte word instance.
        push2(8'h5A); push2(8'hA5);
        for (int c = 0; c < 20 && !word_valid2; c++) @(negedge rd_clk);
        check("wb2_valid", word_valid2, 1);
        check("wb2_word", word_out2, 16'hA55A);
        check("wb2_bytes", word_bytes2, 2);
        tick();
        push2(8'h01); push2(8'hFE);
        for (int c = 0; c < 20 && !word_valid2; c++) @(negedge rd_clk);
        check("wb2_valid2", word_valid2, 1);
        check("wb2_word2", word_out2, 16'hFE01);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
